// File: rtl/pc_pkg.sv
// Shared encodings for the IF-stage program-counter unit: FSM states,
// control-flow opcodes, system instruction words, trap cause codes and mtvec modes.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD_CF   = 2'd1,
        ST_HOLD_MRET = 2'd2
    } pc_state_e;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_UNIMP  = 32'hc000_1073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/pc_trap_vec.sv
// Trap handler address: mtvec base, optionally offset by 4*cause for
// interrupts when mtvec is in vectored mode. MODE values >= 2 fall back to direct.
module pc_trap_vec
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CSR_W       = 64,
    parameter int VECTORED_EN = 1
) (
    input  logic [CSR_W-1:0] mtvec,
    input  logic             is_irq,
    input  logic [3:0]       cause,
    output logic [XLEN-1:0]  target
);

    logic [XLEN-1:0] base;

    always_comb begin
        base   = {mtvec[XLEN-1:2], 2'b00};
        target = base;
        if ((VECTORED_EN != 0) && is_irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
            target = base + XLEN'({cause, 2'b00});
        end
    end

    generate
        if (CSR_W > XLEN) begin : g_unused_hi
            logic unused_mtvec_hi;
            assign unused_mtvec_hi = ^mtvec[CSR_W-1:XLEN];
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential fetch, parking on control flow / mret until
// resolved, trap vectoring through mtvec, and a hold watchdog.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              CSR_W        = 64,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter int              HOLD_TIMEOUT = 15,
    parameter int              VECTORED_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_inst,
    input  logic             if_valid,
    input  logic             stall,
    input  logic             br_resolve,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             set_pc_to_mepc,
    input  logic             exc_req,
    input  logic [3:0]       exc_cause,
    input  logic [XLEN-1:0]  exc_epc,
    input  logic             irq_req,
    input  logic [3:0]       irq_cause,
    input  logic [CSR_W-1:0] mtvec_data,
    input  logic [CSR_W-1:0] mepc_data,
    output logic [XLEN-1:0]  pc,
    output logic             fetch_en,
    output logic             trap_taken,
    output logic             trap_is_irq,
    output logic [3:0]       trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic             hold_timeout
);

    localparam int              WD_W    = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(HOLD_TIMEOUT - 1);

    pc_state_e       state, state_next;
    logic [WD_W-1:0] wd_cnt, wd_next;
    logic [XLEN-1:0] pc_next, pc_inc, mepc_pc, trap_target;
    logic [XLEN-1:0] epc_next;
    logic [3:0]      cause_next, sys_cause, vec_cause;
    logic            trap_next, trap_irq_next, timeout_next;
    logic            sys_hit, is_cf, vec_irq;

    assign pc_inc  = pc + XLEN'(4);
    assign mepc_pc = mepc_data[XLEN-1:0] & ~XLEN'(1);
    assign is_cf   = (if_inst[6:0] == OP_JAL) || (if_inst[6:0] == OP_JALR)
                   || (if_inst[6:0] == OP_BRANCH);

    always_comb begin
        sys_hit   = 1'b1;
        sys_cause = CAUSE_ECALL_M;
        case (if_inst)
            INST_ECALL:  sys_cause = CAUSE_ECALL_M;
            INST_EBREAK: sys_cause = CAUSE_BREAKPOINT;
            INST_UNIMP:  sys_cause = CAUSE_ILLEGAL;
            default:     sys_hit   = 1'b0;
        endcase
    end

    // An irq or system trap only happens in RUN when irq_req decides which; exc_req overrides both.
    assign vec_irq   = !exc_req && irq_req;
    assign vec_cause = exc_req ? exc_cause : (irq_req ? irq_cause : sys_cause);

    pc_trap_vec #(
        .XLEN        (XLEN),
        .CSR_W       (CSR_W),
        .VECTORED_EN (VECTORED_EN)
    ) u_trap_vec (
        .mtvec  (mtvec_data),
        .is_irq (vec_irq),
        .cause  (vec_cause),
        .target (trap_target)
    );

    // if_inst is only acted on when if_valid is high; there is no back-pressure,
    // a held pc simply re-presents the same address to the fetch side.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        wd_next       = wd_cnt;
        trap_next     = 1'b0;
        trap_irq_next = 1'b0;
        cause_next    = trap_cause;
        epc_next      = trap_epc;
        timeout_next  = hold_timeout;

        if (exc_req) begin
            pc_next    = trap_target;
            trap_next  = 1'b1;
            cause_next = exc_cause;
            epc_next   = exc_epc;
            state_next = ST_RUN;
        end else if (set_pc_to_mepc) begin
            pc_next    = mepc_pc;
            state_next = ST_RUN;
        end else if ((state == ST_HOLD_CF) && br_resolve) begin
            pc_next    = br_taken ? (br_target & ~XLEN'(1)) : pc_inc;
            state_next = ST_RUN;
        end else if (state == ST_RUN) begin
            if (if_valid && irq_req) begin
                pc_next       = trap_target;
                trap_next     = 1'b1;
                trap_irq_next = 1'b1;
                cause_next    = irq_cause;
                epc_next      = pc;
            end else if (if_valid && sys_hit) begin
                pc_next    = trap_target;
                trap_next  = 1'b1;
                cause_next = sys_cause;
                epc_next   = pc;
            end else if (if_valid && is_cf) begin
                state_next = ST_HOLD_CF;
            end else if (if_valid && (if_inst == INST_MRET)) begin
                state_next = ST_HOLD_MRET;
            end else if (if_valid && !stall) begin
                pc_next = pc_inc;
            end
        end else if (wd_cnt == WD_LAST) begin
            pc_next      = pc_inc;
            state_next   = ST_RUN;
            timeout_next = 1'b1;
        end else begin
            wd_next = wd_cnt + WD_W'(1);
        end

        if (state_next == ST_RUN) begin
            wd_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            pc           <= RESET_VEC;
            wd_cnt       <= '0;
            fetch_en     <= 1'b1;
            trap_taken   <= 1'b0;
            trap_is_irq  <= 1'b0;
            trap_cause   <= '0;
            trap_epc     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            wd_cnt       <= wd_next;
            fetch_en     <= (state_next == ST_RUN);
            trap_taken   <= trap_next;
            trap_is_irq  <= trap_irq_next;
            trap_cause   <= cause_next;
            trap_epc     <= epc_next;
            hold_timeout <= timeout_next;
        end
    end

    generate
        if (CSR_W > XLEN) begin : g_unused_hi
            logic unused_mepc_hi;
            assign unused_mepc_hi = ^mepc_data[CSR_W-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected pc values queued as each step is driven
// and popped after the clock edge; trap/status outputs checked inline.
module tb_pc_gen;

    localparam int XLEN = 32;
    localparam int CSR_W = 64;

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] JAL   = 32'h0000_006f;
    localparam logic [31:0] JALR  = 32'h0000_8067;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] MRET  = 32'h3020_0073;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      if_inst;
    logic             if_valid, stall, br_resolve, br_taken;
    logic [XLEN-1:0]  br_target, exc_epc;
    logic             set_pc_to_mepc, exc_req, irq_req;
    logic [3:0]       exc_cause, irq_cause;
    logic [CSR_W-1:0] mtvec_data, mepc_data;
    logic [XLEN-1:0]  pc, trap_epc;
    logic             fetch_en, trap_taken, trap_is_irq, hold_timeout;
    logic [3:0]       trap_cause;

    logic [XLEN-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (XLEN),
        .CSR_W        (CSR_W),
        .RESET_VEC    (32'h100),
        .HOLD_TIMEOUT (4),
        .VECTORED_EN  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .stall          (stall),
        .br_resolve     (br_resolve),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .set_pc_to_mepc (set_pc_to_mepc),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_epc        (exc_epc),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .mtvec_data     (mtvec_data),
        .mepc_data      (mepc_data),
        .pc             (pc),
        .fetch_en       (fetch_en),
        .trap_taken     (trap_taken),
        .trap_is_irq    (trap_is_irq),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .hold_timeout   (hold_timeout)
    );

    // scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input string tag, input logic [XLEN-1:0] exp_pc);
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        chk(tag, 64'(pc), 64'(exp_q.pop_front()));
    endtask

    // drivers
    task automatic idle();
        if_inst        = ADDI;
        if_valid       = 1'b0;
        stall          = 1'b0;
        br_resolve     = 1'b0;
        br_taken       = 1'b0;
        br_target      = '0;
        set_pc_to_mepc = 1'b0;
        exc_req        = 1'b0;
        exc_cause      = '0;
        exc_epc        = '0;
        irq_req        = 1'b0;
        irq_cause      = '0;
    endtask

    task automatic redirect(input logic [XLEN-1:0] addr);
        idle();
        set_pc_to_mepc = 1'b1;
        mepc_data      = 64'(addr);
        cyc("redirect", addr & ~32'h1);
        set_pc_to_mepc = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] inst, input logic [XLEN-1:0] exp_pc);
        idle();
        if_valid = 1'b1;
        if_inst  = inst;
        cyc(tag, exp_pc);
        if_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst        = 1'b1;
        mtvec_data = 64'h1001;
        mepc_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", 64'(pc), 64'h100);
        chk("reset_fetch_en", 64'(fetch_en), 64'h1);
        chk("reset_trap", 64'(trap_taken), 64'h0);
        chk("reset_timeout", 64'(hold_timeout), 64'h0);
        rst = 1'b0;

        // sequential fetch
        for (int i = 1; i <= 4; i++) fetch("seq", ADDI, 32'h100 + 32'(4 * i));
        idle();
        stall = 1'b1;
        if_valid = 1'b1;
        cyc("stall_hold", 32'h110);

        // branch taken / not taken; odd target and odd mepc clear bit 0
        redirect(32'h21);
        fetch("beq_hold", BEQ, 32'h20);
        chk("beq_fetch_en", 64'(fetch_en), 64'h0);
        cyc("beq_park", 32'h20);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h81;
        cyc("br_taken", 32'h80);
        chk("br_taken_fetch_en", 64'(fetch_en), 64'h1);
        redirect(32'h20);
        fetch("beq2_hold", BEQ, 32'h20);
        br_resolve = 1'b1; br_taken = 1'b0; br_target = 32'h81;
        cyc("br_not_taken", 32'h24);
        cyc("br_resolve_in_run", 32'h24);
        br_resolve = 1'b0;

        // ecall through direct handler, then vectored irq
        redirect(32'h40);
        fetch("ecall", ECALL, 32'h1000);
        chk("ecall_trap", 64'(trap_taken), 64'h1);
        chk("ecall_cause", 64'(trap_cause), 64'd11);
        chk("ecall_epc", 64'(trap_epc), 64'h40);
        chk("ecall_is_irq", 64'(trap_is_irq), 64'h0);
        cyc("ecall_after", 32'h1000);
        chk("trap_one_cycle", 64'(trap_taken), 64'h0);
        idle();
        irq_req = 1'b1; irq_cause = 4'd7;
        cyc("irq_no_valid", 32'h1000);
        if_valid = 1'b1;
        cyc("irq_vectored", 32'h101c);
        chk("irq_is_irq", 64'(trap_is_irq), 64'h1);
        chk("irq_cause", 64'(trap_cause), 64'd7);
        chk("irq_epc", 64'(trap_epc), 64'h1000);
        mtvec_data = 64'h1000; irq_cause = 4'd3;
        cyc("irq_direct_mode", 32'h1000);
        mtvec_data = 64'h1001;
        idle();

        // mret park and return
        redirect(32'h1010);
        mepc_data = 64'h44;
        fetch("mret_hold", MRET, 32'h1010);
        chk("mret_fetch_en", 64'(fetch_en), 64'h0);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h300;
        cyc("mret_ignores_br", 32'h1010);
        br_resolve = 1'b0;
        cyc("mret_park", 32'h1010);
        set_pc_to_mepc = 1'b1;
        cyc("mret_return", 32'h44);
        chk("mret_fetch_en_run", 64'(fetch_en), 64'h1);

        // exception beats mepc redirect in the same cycle
        idle();
        set_pc_to_mepc = 1'b1; mepc_data = 64'h88;
        exc_req = 1'b1; exc_cause = 4'd5; exc_epc = 32'h44;
        cyc("exc_wins", 32'h1000);
        chk("exc_trap", 64'(trap_taken), 64'h1);
        chk("exc_cause", 64'(trap_cause), 64'd5);
        chk("exc_epc", 64'(trap_epc), 64'h44);
        idle();

        // watchdog release and sticky flag
        redirect(32'h60);
        fetch("jal_hold", JAL, 32'h60);
        for (int i = 0; i < 3; i++) cyc("wd_wait", 32'h60);
        chk("wd_not_yet", 64'(hold_timeout), 64'h0);
        cyc("wd_fire", 32'h64);
        chk("wd_flag", 64'(hold_timeout), 64'h1);
        chk("wd_fetch_en", 64'(fetch_en), 64'h1);
        fetch("after_wd", ADDI, 32'h68);
        chk("wd_sticky", 64'(hold_timeout), 64'h1);
        fetch("jalr_hold", JALR, 32'h68);
        for (int i = 0; i < 3; i++) cyc("wd2_wait", 32'h68);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h201;
        cyc("resolve_beats_wd", 32'h200);
        idle();

        // wrap and reset mid-hold
        redirect(32'hffff_fffc);
        fetch("wrap", ADDI, 32'h0);
        fetch("hold_before_rst", BEQ, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", 64'(pc), 64'h100);
        chk("async_rst_fetch_en", 64'(fetch_en), 64'h1);
        chk("async_rst_timeout", 64'(hold_timeout), 64'h0);
        chk("async_rst_trap", 64'(trap_taken), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch("run_after_rst", ADDI, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
